full_subtractor: RTL and testbench

- Registered full subtractor: computes Diff = A − B − Borrow_in and Borrow_out over WIDTH bits.
- Used as an arithmetic leaf in datapaths; at the default WIDTH=1 it is the classic 1-bit full subtractor with a registered output stage.
- Built as a ripple chain of 1-bit subtractor cells feeding an output register with a valid flag.

---
 rtl/full_subtractor_pkg.sv | 13 +
 rtl/full_subtractor_bit_cell.sv | 16 +
 rtl/full_subtractor.sv | 59 +++++
 tb/tb_full_subtractor.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/full_subtractor_pkg.sv
// Shared definitions for the registered full subtractor.
// Holds the operand width limit and the per-bit borrow equation.
package full_subtractor_pkg;

  localparam int unsigned FS_MIN_WIDTH = 32'd1;
  localparam int unsigned FS_MAX_WIDTH = 32'd64;

  // A borrow leaves the bit when b exceeds a, or when a equals b and a borrow came in.
  function automatic logic fs_borrow(input logic a, input logic b, input logic bw);
    return (~a & b) | (~(a ^ b) & bw);
  endfunction

endpackage

// File: rtl/full_subtractor_bit_cell.sv
// Purely combinational 1-bit full subtractor cell; one link of the ripple borrow chain.
// Named fs_bit_cell so the top can instantiate it once per bit.
module fs_bit_cell
  import full_subtractor_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic bw_in,
  output logic d,
  output logic bw_out
);

  assign d      = a ^ b ^ bw_in;
  assign bw_out = fs_borrow(a, b, bw_in);

endmodule

// File: rtl/full_subtractor.sv
// WIDTH-bit ripple-borrow subtractor with a registered result and valid flag.
// Diff/Borrow_out only update on accepted operands; idle cycles hold them and drop out_valid.
module full_subtractor
  import full_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = 32'd1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Borrow_in,
  output logic [WIDTH-1:0] Diff,
  output logic             Borrow_out,
  output logic             out_valid
);

  logic [WIDTH:0]   bw_s;
  logic [WIDTH-1:0] d_s;
  logic [WIDTH-1:0] diff_r;
  logic             borrow_r;
  logic             valid_r;

  assign bw_s[0] = Borrow_in;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    fs_bit_cell u_cell (
      .a      (A[i]),
      .b      (B[i]),
      .bw_in  (bw_s[i]),
      .d      (d_s[i]),
      .bw_out (bw_s[i+1])
    );
  end

  // Output stage: capture the chain result on accepted operands, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff_r   <= {WIDTH{1'b0}};
      borrow_r <= 1'b0;
      valid_r  <= 1'b0;
    end else begin
      valid_r <= in_valid;
      if (in_valid) begin
        diff_r   <= d_s;
        borrow_r <= bw_s[WIDTH];
      end else begin
        diff_r   <= diff_r;
        borrow_r <= borrow_r;
      end
    end
  end

  assign Diff       = diff_r;
  assign Borrow_out = borrow_r;
  assign out_valid  = valid_r;

endmodule

// File: tb/tb_full_subtractor.sv
// Scoreboard bench: three widths (1, 8, 16) share one clock and reset.
// Drivers push model results into per-instance queues; a negedge monitor pops and compares.
module tb_full_subtractor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        iv1, a1, b1, bi1, d1, bo1, ov1;
  logic        iv8, bi8, bo8, ov8;
  logic [7:0]  a8, b8, d8;
  logic        iv16, bi16, bo16, ov16;
  logic [15:0] a16, b16, d16;

  full_subtractor #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .A(a1), .B(b1), .Borrow_in(bi1),
    .Diff(d1), .Borrow_out(bo1), .out_valid(ov1));
  full_subtractor #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .A(a8), .B(b8), .Borrow_in(bi8),
    .Diff(d8), .Borrow_out(bo8), .out_valid(ov8));
  full_subtractor #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .A(a16), .B(b16), .Borrow_in(bi16),
    .Diff(d16), .Borrow_out(bo16), .out_valid(ov16));

  int total = 0;
  int bad = 0;
  logic [16:0] sq[3][$];
  logic [16:0] last[3];
  int          wid[3] = '{1, 8, 16};
  string       nm[3] = '{"w1", "w8", "w16"};

  // Reference: plain signed arithmetic; borrow is simply "result went negative".
  function automatic logic [16:0] model(input int w, input logic [15:0] a,
                                        input logic [15:0] b, input logic bin);
    longint r;
    longint m;
    logic [16:0] e;
    r = longint'(a) - longint'(b) - longint'(bin);
    m = (longint'(1) << w) - longint'(1);
    e[15:0] = 16'(r & m);
    e[16]   = (r < 0);
    return e;
  endfunction

  // Packed compare value: {out_valid, borrow, diff[15:0]}.
  task automatic check(input string name, input logic [17:0] got, input logic [17:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got valid=%b bout=%b diff=%h, want valid=%b bout=%b diff=%h",
               name, got[17], got[16], got[15:0], exp[17], exp[16], exp[15:0]);
    end
  endtask

  task automatic mon(input int k, input logic ov, input logic [16:0] got);
    logic [16:0] e;
    if (!rst_n) begin
      check({nm[k], "_reset"}, {ov, got}, 18'd0);
      sq[k].delete();
      last[k] = 17'd0;
    end else if (sq[k].size() > 0) begin
      e = sq[k].pop_front();
      check({nm[k], "_result"}, {ov, got}, {1'b1, e});
      last[k] = e;
    end else begin
      check({nm[k], "_hold"}, {ov, got}, {1'b0, last[k]});
    end
  endtask

  always @(negedge clk) begin
    mon(0, ov1, {bo1, 15'd0, d1});
    mon(1, ov8, {bo8, 8'd0, d8});
    mon(2, ov16, {bo16, d16});
  end

  // Present one operand set to instance k for one clock; others stay idle.
  task automatic drive(input int k, input logic [15:0] a, input logic [15:0] b,
                       input logic bin, input logic v);
    iv1 = 1'b0; iv8 = 1'b0; iv16 = 1'b0;
    case (k)
      0: begin a1 = a[0]; b1 = b[0]; bi1 = bin; iv1 = v; end
      1: begin a8 = a[7:0]; b8 = b[7:0]; bi8 = bin; iv8 = v; end
      default: begin a16 = a; b16 = b; bi16 = bin; iv16 = v; end
    endcase
    @(posedge clk);
    if (v) sq[k].push_back(model(wid[k], a, b, bin));
    #1;
  endtask

  initial begin
    iv1 = 1'b0; a1 = 1'b0; b1 = 1'b0; bi1 = 1'b0;
    iv8 = 1'b0; a8 = 8'd0; b8 = 8'd0; bi8 = 1'b0;
    iv16 = 1'b0; a16 = 16'd0; b16 = 16'd0; bi16 = 1'b0;
    last[0] = 17'd0; last[1] = 17'd0; last[2] = 17'd0;

    // Reset held while inputs toggle with in_valid high.
    for (int i = 0; i < 4; i++) begin
      iv1 = 1'b1; iv8 = 1'b1; iv16 = 1'b1;
      a1 = 1'($urandom); b1 = 1'($urandom); bi1 = 1'($urandom);
      a8 = 8'($urandom); b8 = 8'($urandom); bi8 = 1'($urandom);
      a16 = 16'($urandom); b16 = 16'($urandom); bi16 = 1'($urandom);
      @(posedge clk);
      #1;
    end
    iv1 = 1'b0; iv8 = 1'b0; iv16 = 1'b0;
    rst_n = 1'b1;
    drive(0, 16'd0, 16'd0, 1'b0, 1'b0);

    // WIDTH=1 truth table.
    for (int r = 0; r < 8; r++) begin
      drive(0, 16'(r >> 2), 16'((r >> 1) & 1), 1'(r & 1), 1'b1);
    end
    // Hold: next operands ignored (including unknowns on WIDTH=1) while in_valid is low.
    drive(0, 16'd1, 16'd0, 1'b0, 1'b1);
    drive(0, 16'd0, 16'd1, 1'b1, 1'b0);
    iv1 = 1'b0; a1 = 1'bx; b1 = 1'bx; bi1 = 1'bx;
    @(posedge clk); #1;
    @(posedge clk); #1;
    a1 = 1'b0; b1 = 1'b0; bi1 = 1'b0;

    // WIDTH=8 boundaries, then back-to-back throughput.
    drive(1, 16'h00, 16'hFF, 1'b1, 1'b1);
    drive(1, 16'hFF, 16'h00, 1'b0, 1'b1);
    drive(1, 16'h80, 16'h80, 1'b1, 1'b1);
    drive(1, 16'h10, 16'h01, 1'b0, 1'b1);
    drive(1, 16'h05, 16'h07, 1'b0, 1'b1);
    drive(1, 16'h00, 16'h00, 1'b0, 1'b0);

    // Asynchronous reset mid-cycle with a fresh result on the outputs.
    drive(1, 16'h10, 16'h01, 1'b0, 1'b1);
    check("w8_pre_async", {ov8, bo8, 8'd0, d8}, {1'b1, 1'b0, 16'h000F});
    #1 rst_n = 1'b0;
    #1 check("w8_async_clear", {ov8, bo8, 8'd0, d8}, 18'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    drive(1, 16'h00, 16'h00, 1'b0, 1'b0);
    drive(1, 16'h33, 16'h11, 1'b1, 1'b1);

    // WIDTH=16 randomized with random in_valid.
    for (int i = 0; i < 1000; i++) begin
      drive(2, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)));
    end
    drive(2, 16'd0, 16'd0, 1'b0, 1'b0);
    drive(2, 16'd0, 16'd0, 1'b0, 1'b0);

    for (int k = 0; k < 3; k++) begin
      total++;
      if (sq[k].size() != 0) begin
        bad++;
        $display("FAIL %s_drain: got %0d pending results, want 0", nm[k], sq[k].size());
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
